// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between the instruction-fetch side and the
// data side. Data requests win arbitration, but a streak counter forces a
// fetch grant after MAX_DSTREAK consecutive data grants taken while a fetch
// was waiting.
//
// Ports:
//   CLK, nRST                   clock, asynchronous active-low reset
//   iREN, iaddr                 fetch request and address
//   dREN, dWEN, daddr, dstore   data read/write request, address, write value
//   iwait, dwait                per-side "not complete this cycle"
//   iload, dload                per-side returned word (completion cycle only)
//   ramREN, ramWEN, ramaddr,
//   ramstore                    RAM request outputs
//   ramload, ramstate           RAM read data and status (0 FREE, 1 BUSY,
//                               2 ACCESS, 3 ERROR)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no owner; arbitrate between the two sides, strobes low
// IACC  | fetch side owns the RAM port until ramstate reports ACCESS
// DACC  | data side owns the RAM port until ramstate reports ACCESS
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              iwait,
  output logic              dwait,
  output logic [DATA_W-1:0] iload,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_DSTREAK);
  localparam logic [1:0] RS_ACCESS = 2'd2;

  typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

  state_t        state, next_state;
  logic [SW-1:0] streak, streak_next;
  logic          d_req;
  logic          icomp, dcomp;

  assign d_req = dREN | dWEN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= next_state;
      streak <= streak_next;
    end
  end

  always_comb begin
    next_state  = state;
    streak_next = streak;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    icomp       = 1'b0;
    dcomp       = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !(iREN && streak == SMAX)) begin
          next_state = DACC;
          // Only data grants that overtake a waiting fetch count toward the streak.
          if (iREN)
            streak_next = (streak == SMAX) ? SMAX : streak + 1'b1;
          else
            streak_next = '0;
        end else if (iREN) begin
          next_state  = IACC;
          streak_next = '0;
        end
      end
      IACC: begin
        // Dropping the request aborts: strobes fall this cycle, nothing completes.
        if (!iREN) begin
          next_state = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ramstate == RS_ACCESS) begin
            icomp      = 1'b1;
            next_state = IDLE;
          end
        end
      end
      DACC: begin
        if (!d_req) begin
          next_state = IDLE;
        end else begin
          ramREN   = dREN;
          ramWEN   = dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          if (ramstate == RS_ACCESS) begin
            dcomp      = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign iwait = iREN & ~icomp;
  assign dwait = d_req & ~dcomp;
  assign iload = icomp ? ramload : '0;
  assign dload = dcomp ? ramload : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // ---- 1: reset with fetch pending and RAM reporting ACCESS
    nRST = 1'b0; iREN = 1'b1; dREN = 1'b0; dWEN = 1'b0;
    iaddr = 32'h100; daddr = 32'h0; dstore = 32'h0;
    ramload = 32'h1111_1111; ramstate = ACC;
    #1;
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_iwait", iwait, 1);
    chk("rst_dwait", dwait, 0);
    chk("rst_iload", iload, 0);
    tick(); tick();
    chk("rst_hold_ramREN", ramREN, 0);
    nRST = 1'b1; #1;
    chk("t1_grant_ramREN", ramREN, 0);
    chk("t1_grant_iwait", iwait, 1);
    tick();
    chk("t1_acc_ramREN", ramREN, 1);
    chk("t1_acc_ramaddr", ramaddr, 32'h100);
    chk("t1_acc_iwait", iwait, 0);
    chk("t1_acc_iload", iload, 32'h1111_1111);
    tick();
    iREN = 1'b0; #1;
    chk("t1_idle_ramREN", ramREN, 0);
    chk("t1_idle_iwait", iwait, 0);
    chk("t1_idle_iload", iload, 0);

    // ---- 2: simultaneous fetch and data read, data wins
    iREN = 1'b1; dREN = 1'b1; daddr = 32'h200; ramload = 32'h2222_2222; #1;
    chk("t2_c1_ramREN", ramREN, 0);
    chk("t2_c1_dwait", dwait, 1);
    chk("t2_c1_iwait", iwait, 1);
    tick();
    chk("t2_c2_ramaddr", ramaddr, 32'h200);
    chk("t2_c2_dwait", dwait, 0);
    chk("t2_c2_dload", dload, 32'h2222_2222);
    chk("t2_c2_iwait", iwait, 1);
    chk("t2_c2_iload", iload, 0);
    tick();
    dREN = 1'b0; #1;
    chk("t2_c3_ramREN", ramREN, 0);
    chk("t2_c3_iwait", iwait, 1);
    tick();
    chk("t2_c4_ramaddr", ramaddr, 32'h100);
    chk("t2_c4_iwait", iwait, 0);
    chk("t2_c4_iload", iload, 32'h2222_2222);
    tick();
    iREN = 1'b0; #1;

    // ---- 3: continuous data + fetch: 4 data grants then 1 fetch, twice
    iREN = 1'b1; dREN = 1'b1; daddr = 32'h204; ramload = 32'h3333_3333; #1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        chk("t3_dgrant_ramREN", ramREN, 0);
        chk("t3_dgrant_dwait", dwait, 1);
        tick();
        chk("t3_dacc_ramaddr", ramaddr, 32'h204);
        chk("t3_dacc_dwait", dwait, 0);
        chk("t3_dacc_iwait", iwait, 1);
        tick();
      end
      chk("t3_igrant_ramREN", ramREN, 0);
      chk("t3_igrant_iwait", iwait, 1);
      tick();
      chk("t3_iacc_ramaddr", ramaddr, 32'h100);
      chk("t3_iacc_iwait", iwait, 0);
      chk("t3_iacc_dwait", dwait, 1);
      chk("t3_iacc_iload", iload, 32'h3333_3333);
      tick();
    end
    iREN = 1'b0; dREN = 1'b0; #1;

    // ---- 4: data write with 3 BUSY cycles
    dWEN = 1'b1; daddr = 32'h40; dstore = 32'hDEAD_BEEF; ramstate = BUSY; #1;
    chk("t4_grant_ramWEN", ramWEN, 0);
    chk("t4_grant_dwait", dwait, 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("t4_busy_ramWEN", ramWEN, 1);
      chk("t4_busy_ramREN", ramREN, 0);
      chk("t4_busy_ramaddr", ramaddr, 32'h40);
      chk("t4_busy_ramstore", ramstore, 32'hDEAD_BEEF);
      chk("t4_busy_dwait", dwait, 1);
      tick();
    end
    ramstate = ACC; #1;
    chk("t4_acc_ramWEN", ramWEN, 1);
    chk("t4_acc_ramstore", ramstore, 32'hDEAD_BEEF);
    chk("t4_acc_dwait", dwait, 0);
    tick();
    dWEN = 1'b0; #1;
    chk("t4_idle_ramWEN", ramWEN, 0);

    // ---- 5: fetch with 2 ERROR cycles then ACCESS
    iREN = 1'b1; iaddr = 32'h300; ramstate = ERR; ramload = 32'h5555_5555; #1;
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("t5_err_ramREN", ramREN, 1);
      chk("t5_err_ramaddr", ramaddr, 32'h300);
      chk("t5_err_iwait", iwait, 1);
      chk("t5_err_iload", iload, 0);
      tick();
    end
    ramstate = ACC; #1;
    chk("t5_acc_iwait", iwait, 0);
    chk("t5_acc_iload", iload, 32'h5555_5555);
    tick();
    iREN = 1'b0; #1;
    chk("t5_idle_ramREN", ramREN, 0);
    chk("t5_idle_iload", iload, 0);

    // ---- 6a: data read aborted mid-access
    dREN = 1'b1; daddr = 32'h50; ramstate = BUSY; #1;
    tick();
    chk("t6a_dacc_ramREN", ramREN, 1);
    dREN = 1'b0; #1;
    chk("t6a_abort_ramREN", ramREN, 0);
    chk("t6a_abort_dwait", dwait, 0);
    chk("t6a_abort_dload", dload, 0);
    tick();
    ramstate = ACC; #1;
    chk("t6a_idle_ramREN", ramREN, 0);
    chk("t6a_idle_dload", dload, 0);

    // ---- 6b: async reset mid-fetch
    iREN = 1'b1; iaddr = 32'h400; ramstate = BUSY; #1;
    tick();
    chk("t6b_iacc_ramREN", ramREN, 1);
    nRST = 1'b0; #1;
    chk("t6b_rst_ramREN", ramREN, 0);
    chk("t6b_rst_iwait", iwait, 1);
    ramstate = ACC; #1;
    chk("t6b_rst_iload", iload, 0);
    tick();
    nRST = 1'b1; #1;
    chk("t6b_regrant_ramREN", ramREN, 0);
    chk("t6b_regrant_iwait", iwait, 1);
    tick();
    chk("t6b_acc_ramaddr", ramaddr, 32'h400);
    chk("t6b_acc_iwait", iwait, 0);
    tick();
    iREN = 1'b0; #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
